// File: rtl/ecg_peak_detector_if.sv
// FIFO read-side handshake between the sample FIFO (slave) and the peak detector (master).
interface ecg_peak_detector_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (input fifo_empty, input fifo_data, output fifo_rd_en);
  modport slave  (output fifo_empty, output fifo_data, input fifo_rd_en);
endinterface

// File: rtl/ecg_peak_detector.sv
// ecg_peak_detector: pops ECG samples from a sync FIFO and reports R-peaks (value, index, R-R interval).
// Optional feature: define ECG_PEAK_COUNT_EN to add a saturating 16-bit peak_count output.
module ecg_peak_detector #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 16,
  parameter int REFRACT    = 50
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic signed [DATA_WIDTH-1:0] threshold,
  ecg_peak_detector_if.master          fifo,
  output logic                         peak_valid,
  output logic signed [DATA_WIDTH-1:0] peak_value,
  output logic        [IDX_WIDTH-1:0]  peak_index,
  output logic        [IDX_WIDTH-1:0]  rr_interval,
  output logic                         busy
`ifdef ECG_PEAK_COUNT_EN
  ,
  output logic        [15:0]           peak_count
`endif
);

  localparam int RC_W = (REFRACT < 1) ? 1 : $clog2(REFRACT + 1);
  localparam logic [IDX_WIDTH-1:0] IDX_ONE = IDX_WIDTH'(1);
  localparam logic [RC_W-1:0]      RC_ONE  = RC_W'(1);
  localparam logic [RC_W-1:0]      RC_LOAD = RC_W'(REFRACT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAP  = 2'd2
  } state_t;

  state_t                       state_r;
  logic                         rd_en_r;
  logic                         above_r;
  logic                         first_peak_r;
  logic        [IDX_WIDTH-1:0]  sample_idx_r;
  logic        [IDX_WIDTH-1:0]  cand_idx_r;
  logic        [IDX_WIDTH-1:0]  last_idx_r;
  logic signed [DATA_WIDTH-1:0] cand_r;
  logic        [RC_W-1:0]       refract_cnt_r;

  logic signed [DATA_WIDTH-1:0] sample_s;
  logic                         gt_thr_s;
  logic                         gt_cand_s;
  logic        [IDX_WIDTH-1:0]  rr_s;

  assign fifo.fifo_rd_en = rd_en_r;

  // Signed comparisons of the FIFO sample and the R-R distance of the pending candidate.
  always_comb begin
    sample_s  = fifo.fifo_data;
    gt_thr_s  = (sample_s > threshold);
    gt_cand_s = (sample_s > cand_r);
    if (first_peak_r) begin
      rr_s = {IDX_WIDTH{1'b0}};
    end else begin
      rr_s = cand_idx_r - last_idx_r;
    end
  end

  // Pop/capture FSM with threshold detection; peak_valid pulses the cycle after CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      rd_en_r       <= 1'b0;
      busy          <= 1'b0;
      above_r       <= 1'b0;
      first_peak_r  <= 1'b1;
      sample_idx_r  <= {IDX_WIDTH{1'b0}};
      cand_idx_r    <= {IDX_WIDTH{1'b0}};
      last_idx_r    <= {IDX_WIDTH{1'b0}};
      cand_r        <= {DATA_WIDTH{1'b0}};
      refract_cnt_r <= {RC_W{1'b0}};
      peak_valid    <= 1'b0;
      peak_value    <= {DATA_WIDTH{1'b0}};
      peak_index    <= {IDX_WIDTH{1'b0}};
      rr_interval   <= {IDX_WIDTH{1'b0}};
    end else begin
      rd_en_r    <= 1'b0;
      peak_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (enable && !fifo.fifo_empty) begin
            state_r <= POP;
            rd_en_r <= 1'b1;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        end
        POP: begin
          state_r <= CAP;
          busy    <= 1'b1;
        end
        CAP: begin
          state_r      <= IDLE;
          busy         <= 1'b0;
          sample_idx_r <= sample_idx_r + IDX_ONE;
          if (refract_cnt_r != {RC_W{1'b0}}) begin
            refract_cnt_r <= refract_cnt_r - RC_ONE;
          end else if (gt_thr_s && !above_r) begin
            above_r    <= 1'b1;
            cand_r     <= sample_s;
            cand_idx_r <= sample_idx_r;
          end else if (gt_thr_s && gt_cand_s) begin
            // Strictly greater only: a plateau keeps the index of its first sample.
            cand_r     <= sample_s;
            cand_idx_r <= sample_idx_r;
          end else if (!gt_thr_s && above_r) begin
            above_r       <= 1'b0;
            refract_cnt_r <= RC_LOAD;
            peak_valid    <= 1'b1;
            peak_value    <= cand_r;
            peak_index    <= cand_idx_r;
            rr_interval   <= rr_s;
            last_idx_r    <= cand_idx_r;
            first_peak_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef ECG_PEAK_COUNT_EN
  // Saturating count of emitted peaks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_count <= 16'h0000;
    end else if (peak_valid && (peak_count != 16'hFFFF)) begin
      peak_count <= peak_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_ecg_peak_detector.sv
// Directed self-checking bench for ecg_peak_detector with a simple FIFO model on the read side.
module tb_ecg_peak_detector;
  localparam int DW = 32;
  localparam int IW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 enable = 1'b0;
  logic signed [DW-1:0] threshold = 32'sd0;
  logic                 peak_valid;
  logic signed [DW-1:0] peak_value;
  logic        [IW-1:0] peak_index;
  logic        [IW-1:0] rr_interval;
  logic                 busy;
`ifdef ECG_PEAK_COUNT_EN
  logic        [15:0]   peak_count;
`endif

  ecg_peak_detector_if #(.DATA_WIDTH(DW)) fifo_bus ();

  ecg_peak_detector #(.DATA_WIDTH(DW), .IDX_WIDTH(IW), .REFRACT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .threshold   (threshold),
    .fifo        (fifo_bus.master),
    .peak_valid  (peak_valid),
    .peak_value  (peak_value),
    .peak_index  (peak_index),
    .rr_interval (rr_interval),
    .busy        (busy)
`ifdef ECG_PEAK_COUNT_EN
    ,
    .peak_count  (peak_count)
`endif
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign fifo_bus.fifo_empty = (wr_ptr == rd_ptr);

  // FIFO model: registered data_out updated on the rd_en edge.
  always @(posedge clk) begin
    if (fifo_bus.fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_bus.fifo_data <= mem[8'(rd_ptr)];
      rd_ptr <= rd_ptr + 1;
    end
  end

  int cyc = 0;
  int rd_cnt = 0;
  int last_rd = -10;
  int rd_viol = 0;
  int pk_n = 0;
  logic signed [DW-1:0] pk_val [0:31];
  logic        [IW-1:0] pk_idx [0:31];
  logic        [IW-1:0] pk_rr  [0:31];
  int                   pk_rdc [0:31];

  // Monitor: rd_en pulse spacing and a log of every emitted peak.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && fifo_bus.fifo_rd_en) begin
      rd_cnt  <= rd_cnt + 1;
      last_rd <= cyc;
      if (cyc - last_rd < 3) rd_viol <= rd_viol + 1;
    end
    if (peak_valid && pk_n < 32) begin
      pk_val[pk_n] <= peak_value;
      pk_idx[pk_n] <= peak_index;
      pk_rr[pk_n]  <= rr_interval;
      pk_rdc[pk_n] <= rd_cnt;
      pk_n         <= pk_n + 1;
    end
  end

  task automatic push(input logic [DW-1:0] v);
    mem[8'(wr_ptr)] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_zeros(input int n);
    for (int i = 0; i < n; i++) push(32'd0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (!((wr_ptr == rd_ptr) && !busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (n >= 600) begin
      tests_failed++;
      $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    enable = 1'b0;
    apply_reset();
    tests_run++;
    if ({peak_valid, busy, fifo_bus.fifo_rd_en} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b, required 000", {peak_valid, busy, fifo_bus.fifo_rd_en});
    end
    tests_run++;
    if ({peak_value, peak_index, rr_interval} !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_data: value %0d index %0d rr %0d, required 0", peak_value, peak_index, rr_interval);
    end
  endtask

  task automatic test_single_peak(output int base);
    int rc0;
    apply_reset();
    threshold = 32'sd100;
    enable = 1'b1;
    base = pk_n;
    rc0 = rd_cnt;
    push(32'd0); push(32'd50); push(32'd150); push(32'd300);
    push(32'd200); push(32'd90); push(32'd0);
    drain("single");
    tests_run++;
    if (pk_n - base !== 1) begin
      tests_failed++;
      $display("FAIL single_count: got %0d peaks, required 1", pk_n - base);
    end
    tests_run++;
    if (pk_val[base] !== 32'sd300 || pk_idx[base] !== 16'd3 || pk_rr[base] !== 16'd0) begin
      tests_failed++;
      $display("FAIL single_peak: got %0d/%0d/%0d, required 300/3/0", pk_val[base], pk_idx[base], pk_rr[base]);
    end
    tests_run++;
    if (pk_rdc[base] - rc0 !== 6) begin
      tests_failed++;
      $display("FAIL single_timing: %0d pops before emit, required 6", pk_rdc[base] - rc0);
    end
    tests_run++;
    if (peak_value !== 32'sd300 || peak_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_hold: value %0d valid %b, required 300 0", peak_value, peak_valid);
    end
  endtask

  task automatic test_second_peak(input int base);
    push_zeros(13);
    push(32'd250);
    push(32'd0);
    drain("second");
    tests_run++;
    if (pk_n - base !== 2) begin
      tests_failed++;
      $display("FAIL second_count: got %0d peaks, required 2", pk_n - base);
    end
    tests_run++;
    if (pk_val[base+1] !== 32'sd250 || pk_idx[base+1] !== 16'd20 || pk_rr[base+1] !== 16'd17) begin
      tests_failed++;
      $display("FAIL second_peak: got %0d/%0d/%0d, required 250/20/17", pk_val[base+1], pk_idx[base+1], pk_rr[base+1]);
    end
  endtask

  task automatic test_refractory();
    int base;
    apply_reset();
    threshold = 32'sd100;
    enable = 1'b1;
    base = pk_n;
    push(32'd0); push(32'd50); push(32'd150); push(32'd300); push(32'd200); push(32'd90);
    for (int i = 0; i < 4; i++) push(32'd500);
    push(32'd120);
    push(32'd0);
    drain("refract");
    tests_run++;
    if (pk_n - base !== 2) begin
      tests_failed++;
      $display("FAIL refract_count: got %0d peaks, required 2", pk_n - base);
    end
    tests_run++;
    if (pk_val[base+1] !== 32'sd120 || pk_idx[base+1] !== 16'd10 || pk_rr[base+1] !== 16'd7) begin
      tests_failed++;
      $display("FAIL refract_peak: got %0d/%0d/%0d, required 120/10/7", pk_val[base+1], pk_idx[base+1], pk_rr[base+1]);
    end
`ifdef ECG_PEAK_COUNT_EN
    tests_run++;
    if (peak_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL peak_count: got %0d, required 2", peak_count);
    end
    apply_reset();
    tests_run++;
    if (peak_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL peak_count_reset: got %0d, required 0", peak_count);
    end
`endif
  endtask

  task automatic test_plateau_threshold();
    int base;
    apply_reset();
    threshold = 32'sd100;
    enable = 1'b1;
    base = pk_n;
    push(32'd150); push(32'd300); push(32'd300); push(32'd50);
    push_zeros(4);
    push(32'd100); push(32'd100); push(32'd0);
    push(32'd101); push(32'd0);
    drain("plateau");
    tests_run++;
    if (pk_n - base !== 2) begin
      tests_failed++;
      $display("FAIL plateau_count: got %0d peaks, required 2", pk_n - base);
    end
    tests_run++;
    if (pk_val[base] !== 32'sd300 || pk_idx[base] !== 16'd1 || pk_rr[base] !== 16'd0) begin
      tests_failed++;
      $display("FAIL plateau_tie: got %0d/%0d/%0d, required 300/1/0", pk_val[base], pk_idx[base], pk_rr[base]);
    end
    tests_run++;
    if (pk_val[base+1] !== 32'sd101 || pk_idx[base+1] !== 16'd11 || pk_rr[base+1] !== 16'd10) begin
      tests_failed++;
      $display("FAIL threshold_edge: got %0d/%0d/%0d, required 101/11/10", pk_val[base+1], pk_idx[base+1], pk_rr[base+1]);
    end
  endtask

  task automatic test_handshake();
    int rc;
    int n;
    enable = 1'b1;
    rc = rd_cnt;
    repeat (10) @(negedge clk);
    tests_run++;
    if (rd_cnt !== rc || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_hold: pops %0d busy %b, required 0 0", rd_cnt - rc, busy);
    end
    enable = 1'b0;
    push(32'd0); push(32'd0); push(32'd0);
    repeat (3) @(negedge clk);
    rc = rd_cnt;
    enable = 1'b1;
    n = 0;
    while (fifo_bus.fifo_rd_en !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    enable = 1'b0;
    repeat (10) @(negedge clk);
    tests_run++;
    if (n >= 20 || rd_cnt - rc !== 1 || wr_ptr - rd_ptr !== 2 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL enable_drop: pops %0d left %0d busy %b, required 1 2 0", rd_cnt - rc, wr_ptr - rd_ptr, busy);
    end
    enable = 1'b1;
    drain("handshake");
    tests_run++;
    if (rd_viol !== 0) begin
      tests_failed++;
      $display("FAIL rd_spacing: %0d violations, required 0", rd_viol);
    end
  endtask

  task automatic test_reset_mid_candidate();
    int base;
    apply_reset();
    threshold = 32'sd100;
    enable = 1'b1;
    base = pk_n;
    push(32'd150); push(32'd300);
    drain("midcand_a");
    apply_reset();
    push(32'd150); push(32'd0);
    drain("midcand_b");
    tests_run++;
    if (pk_n - base !== 1) begin
      tests_failed++;
      $display("FAIL midcand_count: got %0d peaks, required 1", pk_n - base);
    end
    tests_run++;
    if (pk_val[base] !== 32'sd150 || pk_idx[base] !== 16'd0 || pk_rr[base] !== 16'd0) begin
      tests_failed++;
      $display("FAIL midcand_peak: got %0d/%0d/%0d, required 150/0/0", pk_val[base], pk_idx[base], pk_rr[base]);
    end
  endtask

  initial begin
    int base;
    test_reset();
    test_single_peak(base);
    test_second_peak(base);
    test_refractory();
    test_plateau_threshold();
    test_handshake();
    test_reset_mid_candidate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
